// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 bit-select datapath: grants one requester
// for up to MAX_HOLD accepted transfers, then rotates priority with no idle bubble.
module mux8_rr_sched #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   input  logic       ready,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       gnt_valid,
   output logic       dout,
   output logic       dout_valid,
   output logic       dbg_state
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   state_e        state_q;
   logic [2:0]    ptr_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    sel_q;
   logic [7:0]    gnt_q;
   logic          dout_q;
   logic          dout_valid_q;

   logic          xfer;
   logic          rel;
   logic [2:0]    arb_ptr;
   logic [3:0]    pick;

   // Returns {found, index}; iterating from the far end lets the nearest set bit win.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      xfer    = 1'b0;
      rel     = 1'b0;
      arb_ptr = ptr_q;
      if (state_q == S_GRANT) begin
         xfer = ready && req[sel_q];
         rel  = !req[sel_q] || (xfer && (cnt_q == CW'(MAX_HOLD - 1)));
      end
      // On release the old grantee becomes lowest priority for the same-cycle re-arbitration.
      if (rel) arb_ptr = sel_q + 3'd1;
      pick = rr_pick(req, arb_ptr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= 3'd0;
         cnt_q        <= '0;
         sel_q        <= 3'd0;
         gnt_q        <= 8'd0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_valid_q <= xfer;
         case (state_q)
            S_IDLE: begin
               if (pick[3]) begin
                  sel_q   <= pick[2:0];
                  gnt_q   <= 8'd1 << pick[2:0];
                  cnt_q   <= '0;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (xfer) begin
                  dout_q <= din[sel_q];
                  cnt_q  <= cnt_q + CW'(1);
               end
               if (rel) begin
                  ptr_q <= sel_q + 3'd1;
                  if (pick[3]) begin
                     sel_q <= pick[2:0];
                     gnt_q <= 8'd1 << pick[2:0];
                     cnt_q <= '0;
                  end else begin
                     gnt_q   <= 8'd0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sel        = sel_q;
   assign gnt        = gnt_q;
   assign gnt_valid  = |gnt_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares the 8:1 bit-select datapath between eight requesters. It arbitrates the `req` lines and drives the 3-bit select and a one-hot grant. It holds a grant for up to `MAX_HOLD` accepted transfers, then rotates priority. It also registers the selected data bit with a valid strobe for the downstream consumer.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum accepted transfers per grant before forced release; legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request per requester; level-sensitive, held while requester has data.
- `din`  in  8: data bit per requester; `din[k]` belongs to requester k.
- `ready`  in  1: downstream accepts a transfer this cycle.
- `sel`  out  3: registered select of current grantee; feeds mux select.
- `gnt`  out  8: registered one-hot grant; all-zero when idle.
- `gnt_valid`  out  1: a grant is active; equals OR of `gnt`.
- `dout`  out  1: registered data bit of the accepted transfer.
- `dout_valid`  out  1: `dout` is valid this cycle; single-cycle pulse per transfer.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: `gnt[sel]`=1.
- Priority pointer `ptr` (3 bits) names the highest-priority requester.
  - Search order is `ptr`, `ptr`+1, … `ptr`+7, modulo 8.
  - First set `req` bit in that order wins.
- Hold counter `cnt` has width clog2(`MAX_HOLD`+1) and counts accepted transfers in the current grant.
- IDLE, any `req` set: register winner into `sel`/`gnt`, `cnt`<=0, go to GRANT.
- IDLE, no `req`: stay in IDLE with outputs at idle values.
- GRANT, transfer condition: `ready`=1 and `req[sel]`=1.
  - `dout`<=`din[sel]`, `dout_valid`<=1, `cnt`<=`cnt`+1.
  - When no transfer occurs: `dout_valid`<=0 and `dout` holds its value.
- Release in GRANT happens on either event:
  - (a) `req[sel]`=0: release with no transfer that cycle.
  - (b) A transfer occurs with `cnt`=`MAX_HOLD`-1: release after that transfer.
- On release:
  - `ptr`<=`sel`+1 (wraps 7->0).
  - Re-arbitrate in the same cycle using the current `req` and the new pointer value.
  - If a winner exists: load the new `sel`/`gnt`, `cnt`<=0, stay in GRANT. There is no idle bubble.
  - If no winner: `gnt`<=0, go to IDLE.
- Releasing requester that is still requesting is searched last. It is regranted only if it is the sole requester.
- `sel` holds its last value in IDLE. Consumers qualify it with `gnt_valid`.
- Non-grantee `req`/`din` changes have no effect during a grant.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0, including mid-grant):
  - `sel`=0, `gnt`=0, `gnt_valid`=0, `dout`=0, `dout_valid`=0.
  - `ptr`=0, `cnt`=0, state IDLE.
- First grant: `req` sampled at edge N in IDLE -> `gnt`/`sel` valid after edge N.
- Transfer latency:
  - Condition true at edge M -> `dout`/`dout_valid` valid after edge M, for one cycle.
  - Earliest first transfer is one cycle after the grant appears.
- Peak throughput: one transfer per cycle during a grant, including across back-to-back grant handover.
- Releases and regrants coincide with the same edge as the final transfer.
- `ready`=0 stalls the grant indefinitely. `cnt` does not advance and there is no timeout.
- Simultaneous release by (a) and (b) cannot occur, because (b) requires `req[sel]`=1.

## Test plan
- Reset/idle:
  - Assert `rst_n`=0 mid-grant -> all outputs 0 immediately.
  - Release with `req`=0 -> outputs stay 0, `gnt`=0 indefinitely.
- Single requester, `MAX_HOLD`=4:
  - Stimulus: `req`=8'h08, `ready`=1, `din[3]` toggling.
  - Response: `gnt`=8'h08, `sel`=3 from cycle 1; 4 `dout_valid` pulses carrying `din[3]`; regrant to 3 with no bubble; 8 pulses in 8 cycles.
- Round-robin rotation:
  - Stimulus: `req`=8'hFF, `ready`=1, `MAX_HOLD`=1.
  - Response: `sel` sequence 0,1,2,…,7,0 with one grant per cycle and `dout_valid` continuously high after the first transfer.
- Wrap and early release:
  - Stimulus: `req`=8'h81, grant at 7; drop `req[7]` after 2 transfers.
  - Response: release with no transfer that cycle; `ptr`=0; `sel`=0 next; `dout_valid` low for that one cycle.
- Backpressure:
  - Stimulus: grant to 2, `ready`=0 for 5 cycles, then 1.
  - Response: `dout_valid`=0 and `gnt` stable throughout the stall; transfers resume and `MAX_HOLD` counts only accepted transfers.
